// File: rtl/pipe_seq_ctrl_if.sv
// Handshake bundle between the sequencing controller and the datapath it paces.
// master = controller side, slave = datapath / environment side.
interface pipe_seq_ctrl_if #(
   parameter int IDX_W = 8
);
   logic             start;
   logic             out_ready;
   logic             pipe_en;
   logic             in_rd;
   logic [IDX_W-1:0] in_idx;
   logic             out_valid;
   logic [IDX_W-1:0] out_idx;
   logic             busy;
   logic             done;

   modport master (
      input  start, out_ready,
      output pipe_en, in_rd, in_idx, out_valid, out_idx, busy, done
   );

   modport slave (
      output start, out_ready,
      input  pipe_en, in_rd, in_idx, out_valid, out_idx, busy, done
   );
endinterface

// File: rtl/pipe_seq_ctrl.sv
// Sequencer that issues VEC_LEN elements into a fixed-latency pipeline and
// tracks their return, with a global stall driven by downstream out_ready.
//
// state | meaning
// IDLE  | waiting for start, pipeline frozen
// FEED  | issuing elements 0..VEC_LEN-1 into the pipeline
// DRAIN | all issued, waiting for the remaining output beats
// DONE  | single-cycle completion pulse
module pipe_seq_ctrl #(
   parameter int LATENCY_CYCLES = 23,
   parameter int VEC_LEN        = 8,
   parameter int IDX_W          = 8
) (
   input logic            clk,
   input logic            reset,
   pipe_seq_ctrl_if.master bus
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FEED  = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VEC_LEN - 1);

   state_t                    state;
   state_t                    state_nxt;
   logic [IDX_W-1:0]          iss_cnt;
   logic [IDX_W-1:0]          out_cnt;
   logic [LATENCY_CYCLES-1:0] vld_sr;

   logic busy;
   logic pipe_en;
   logic in_rd;
   logic out_valid;
   logic accept;
   logic done;
   logic last_iss;
   logic last_out;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (bus.start) state_nxt = S_FEED;
         S_FEED:  if (last_iss)  state_nxt = S_DRAIN;
         S_DRAIN: if (last_out)  state_nxt = S_DONE;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      busy      = (state != S_IDLE);
      pipe_en   = busy & bus.out_ready;
      in_rd     = (state == S_FEED) & pipe_en;
      out_valid = vld_sr[LATENCY_CYCLES-1] & busy;
      accept    = out_valid & bus.out_ready;
      done      = (state == S_DONE);
      last_iss  = in_rd & (iss_cnt == LAST_IDX);
      last_out  = accept & (out_cnt == LAST_IDX);
   end

   // Counters saturate on the final element so indices never leave 0..VEC_LEN-1.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         iss_cnt <= '0;
         out_cnt <= '0;
      end else if ((state == S_IDLE) && bus.start) begin
         iss_cnt <= '0;
         out_cnt <= '0;
      end else begin
         if (in_rd && !last_iss) begin
            iss_cnt <= iss_cnt + 1'b1;
         end
         if (accept && !last_out) begin
            out_cnt <= out_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vld_sr <= '0;
      end else if (pipe_en) begin
         vld_sr[0] <= in_rd;
         for (int i = 1; i < LATENCY_CYCLES; i++) begin
            vld_sr[i] <= vld_sr[i-1];
         end
      end
   end

   assign bus.pipe_en   = pipe_en;
   assign bus.in_rd     = in_rd;
   assign bus.in_idx    = iss_cnt;
   assign bus.out_valid = out_valid;
   assign bus.out_idx   = out_cnt;
   assign bus.busy      = busy;
   assign bus.done      = done;

endmodule

// File: tb/tb_pipe_seq_ctrl.sv
// Scoreboard bench: stimulus pushes hand-timed expected events, a negedge
// monitor pops and compares them as the two controller instances emit them.
module tb_pipe_seq_ctrl;

   typedef struct {
      int kind;
      int cyc;
      int idx;
   } ev_t;

   logic clk;
   logic reset;
   logic exp_busy;
   int   cyc;
   int   tests;
   int   fails;
   ev_t  q1[$];
   ev_t  q2[$];

   pipe_seq_ctrl_if #(.IDX_W(8)) if1 ();
   pipe_seq_ctrl_if #(.IDX_W(8)) if2 ();

   pipe_seq_ctrl #(.LATENCY_CYCLES(23), .VEC_LEN(8), .IDX_W(8)) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (if1)
   );

   pipe_seq_ctrl #(.LATENCY_CYCLES(1), .VEC_LEN(1), .IDX_W(8)) u_dut_small (
      .clk   (clk),
      .reset (reset),
      .bus   (if2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic push(input int d, input int kind, input int c, input int idx);
      ev_t e;
      e.kind = kind;
      e.cyc  = c;
      e.idx  = idx;
      if (d == 0) q1.push_back(e);
      else        q2.push_back(e);
   endtask

   task automatic chk(input int d, input int kind, input int idx);
      ev_t e;
      tests++;
      if ((d == 0 && q1.size() == 0) || (d == 1 && q2.size() == 0)) begin
         fails++;
         $display("FAIL event dut%0d: got kind %0d idx %0d at cyc %0d, required no event",
                  d, kind, idx, cyc);
         return;
      end
      if (d == 0) e = q1.pop_front();
      else        e = q2.pop_front();
      if (e.kind != kind || e.cyc != cyc || e.idx != idx) begin
         fails++;
         $display("FAIL event dut%0d: got kind %0d idx %0d cyc %0d, required kind %0d idx %0d cyc %0d",
                  d, kind, idx, cyc, e.kind, e.idx, e.cyc);
      end
   endtask

   // kind: 0 = in_rd, 1 = out_valid, 2 = done
   always @(negedge clk) begin
      if (reset) begin
         tests++;
         if ({if1.pipe_en, if1.in_rd, if1.out_valid, if1.busy, if1.done, if1.in_idx, if1.out_idx,
              if2.pipe_en, if2.in_rd, if2.out_valid, if2.busy, if2.done, if2.in_idx, if2.out_idx} != '0) begin
            fails++;
            $display("FAIL reset_outputs: got busy %0b/%0b in_rd %0b/%0b out_valid %0b/%0b done %0b/%0b, required all 0",
                     if1.busy, if2.busy, if1.in_rd, if2.in_rd, if1.out_valid, if2.out_valid, if1.done, if2.done);
         end
      end else begin
         tests++;
         if (if1.busy !== exp_busy || if1.pipe_en !== (exp_busy & if1.out_ready)) begin
            fails++;
            $display("FAIL busy_pipe_en cyc %0d: got busy %0b pipe_en %0b, required busy %0b pipe_en %0b",
                     cyc, if1.busy, if1.pipe_en, exp_busy, exp_busy & if1.out_ready);
         end
         if (if1.in_rd)     chk(0, 0, int'(if1.in_idx));
         if (if1.out_valid) chk(0, 1, int'(if1.out_idx));
         if (if1.done)      chk(0, 2, 0);
         if (if2.in_rd)     chk(1, 0, int'(if2.in_idx));
         if (if2.out_valid) chk(1, 1, int'(if2.out_idx));
         if (if2.done)      chk(1, 2, 0);
      end
   end

   // scen 0: free-running job, 1: stall cycles 4-8, 2: aborted by reset, 3: small instance
   task automatic run(input int scen, input int ncyc, input int which, input int st_lo, input int st_hi,
                      input int rs_a, input int rs_b, input int busy_last, input int rst_at);
      int   base;
      logic rdy;
      @(posedge clk); #1;
      base = cyc;
      case (scen)
         0: begin
            for (int i = 0; i < 8; i++) push(0, 0, base + 1 + i, i);
            for (int i = 0; i < 8; i++) push(0, 1, base + 24 + i, i);
            push(0, 2, base + 32, 0);
         end
         1: begin
            for (int i = 0; i < 8; i++) push(0, 0, base + ((i < 3) ? 1 + i : 6 + i), i);
            for (int i = 0; i < 8; i++) push(0, 1, base + 29 + i, i);
            push(0, 2, base + 37, 0);
         end
         2: begin
            for (int i = 0; i < 8; i++) push(0, 0, base + 1 + i, i);
         end
         default: begin
            push(1, 0, base + 1, 0);
            push(1, 1, base + 2, 0);
            push(1, 2, base + 3, 0);
         end
      endcase
      if (which == 0) if1.start = 1'b1;
      else            if2.start = 1'b1;
      if1.out_ready = 1'b1;
      if2.out_ready = 1'b1;
      exp_busy      = 1'b0;
      for (int n = 1; n <= ncyc; n++) begin
         @(posedge clk); #1;
         if (which == 0) if1.start = (n == rs_a) || (n == rs_b);
         else            if2.start = 1'b0;
         rdy           = !(n >= st_lo && n <= st_hi);
         if1.out_ready = rdy;
         if2.out_ready = rdy;
         reset         = (rst_at > 0) && (n >= rst_at) && (n < rst_at + 2);
         exp_busy      = (which == 0) && (n <= busy_last) && !reset;
      end
      if1.start = 1'b0;
      if2.start = 1'b0;
   endtask

   initial begin
      tests         = 0;
      fails         = 0;
      exp_busy      = 1'b0;
      reset         = 1'b1;
      if1.start     = 1'b1;
      if2.start     = 1'b1;
      if1.out_ready = 1'b1;
      if2.out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      if1.start = 1'b0;
      if2.start = 1'b0;
      reset     = 1'b0;
      repeat (2) @(posedge clk);

      run(0, 36, 0, 100, 0, -1, -1, 32, 0);
      run(1, 42, 0,   4, 8, -1, -1, 37, 0);
      run(0, 36, 0, 100, 0,  5, 32, 32, 0);
      run(2, 20, 0, 100, 0, -1, -1, 14, 15);
      run(0, 36, 0, 100, 0, -1, -1, 32, 0);
      run(3,  6, 1, 100, 0, -1, -1,  0, 0);

      @(posedge clk); #1;
      tests++;
      if (q1.size() != 0) begin
         fails++;
         $display("FAIL pending_main: got %0d unmatched expected events, required 0", q1.size());
      end
      tests++;
      if (q2.size() != 0) begin
         fails++;
         $display("FAIL pending_small: got %0d unmatched expected events, required 0", q2.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
